muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//   Iterative multiply/divide sequencer for the EX stage. Replaces the single-cycle
//   mult/div path: accepts one MULT/MULTU/DIV/DIVU request, runs a 1-bit-per-cycle
//   shift-add / restoring-divide datapath, stalls the pipeline while busy, and
//   delivers one HI/LO write pulse.
// PARAMETERS
//   DATA_WIDTH  32  operand / HI / LO width
//   CNT_WIDTH   6   iteration counter width; must hold DATA_WIDTH
// PORTS
//   clk        in   1           clock; all state on rising edge
//   rst        in   1           synchronous reset, active-high
//   start      in   1           request valid; sampled only in IDLE
//   op         in   2           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a      in   DATA_WIDTH  multiplicand / dividend
//   src_b      in   DATA_WIDTH  multiplier / divisor
//   cancel     in   1           flush (exception / branch kill); abort, no write
//   stall_req  out  1           hold IF/ID/EX while the op is in flight
//   busy       out  1           state != IDLE
//   done       out  1           one-cycle pulse; result valid
//   we_hi      out  1           HI write enable (pulse, same cycle as done)
//   we_lo      out  1           LO write enable (pulse, same cycle as done)
//   hi_out     out  DATA_WIDTH  product[63:32] or remainder
//   lo_out     out  DATA_WIDTH  product[31:0] or quotient
// BEHAVIOUR
//   Reset: state=IDLE, counter=0; stall_req, busy, done, we_hi, we_lo = 0;
//     hi_out = lo_out = 0. Reset in any state (incl. mid-CALC) discards the op.
//   States: IDLE -> CALC -> DONE -> IDLE; IDLE -> DONE for divide-by-zero.
//   IDLE: on start & !cancel, latch the operand magnitudes (two's-complement abs
//     for signed ops; raw for unsigned), sign_a, sign_b, op; clear the accumulator;
//     counter=0. Go to CALC, or to DONE if op is DIV/DIVU and src_b==0.
//   CALC: one iteration per cycle; counter 0..DATA_WIDTH-1; leave after the
//     iteration with counter==DATA_WIDTH-1.
//     MULT(U): 2*DATA_WIDTH-bit shift-add on the unsigned magnitudes.
//     DIV(U): restoring division, DATA_WIDTH+1-bit partial remainder.
//   DONE (1 cycle): done = we_hi = we_lo = 1; register hi_out/lo_out with sign fix:
//     MULT: negate the 64-bit product if sign_a^sign_b.
//     DIV: negate the quotient if sign_a^sign_b; the remainder takes the sign of
//       the dividend (negate if sign_a).
//     Div-by-zero: lo_out = all-ones, hi_out = src_a as latched (raw, unsigned).
//     0x80000000/0xFFFFFFFF (DIV): lo_out = 0x80000000, hi_out = 0; no trap.
//   Latency: start accepted at edge T -> done at cycle T+DATA_WIDTH+1
//     (T+33 at default); div-by-zero -> done at T+1.
//   stall_req = (IDLE & start & !cancel) | CALC; low in DONE so the stage
//     advances with the result.
//   start while busy: ignored (the requester is stalled; no queueing).
//   cancel: from CALC or DONE -> IDLE next edge; done/we_* forced 0 that cycle.
//     cancel has priority over start in IDLE and over completion in DONE.
//   hi_out/lo_out hold their last value outside DONE; we_* are never high
//     outside DONE.
// TESTING
//   MULT a=0xFFFFFFFD, b=7 -> done at T+33: hi=0xFFFFFFFF, lo=0xFFFFFFEB, we_hi=we_lo=1.
//   MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; stall_req high T..T+32.
//   DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
//   DIV a=5, b=0 -> done at T+1: lo=0xFFFFFFFF, hi=5; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//   cancel at T+10 -> no done/we_*, IDLE at T+11; new start at T+11 completes normally.
//   rst at T+5 mid-CALC -> all outputs 0 next cycle; start asserted while busy -> ignored.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 1-bit-per-cycle MULT/MULTU/DIV/DIVU sequencer with pipeline stall and one-cycle HI/LO write pulse
// Ports: clk, rst (sync, active-high); start/op/src_a/src_b request (op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU);
//   cancel flushes an in-flight op; stall_req/busy status; done/we_hi/we_lo result pulse; hi_out/lo_out result.
module muldiv_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic                  cancel,
    output logic                  stall_req,
    output logic                  busy,
    output logic                  done,
    output logic                  we_hi,
    output logic                  we_lo,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out
);
    localparam int W = DATA_WIDTH;
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]       acc_q, acc_d;
    logic [W-1:0]         b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic                 sa_q, sa_d, sb_q, sb_d, div_q, div_d;
    logic                 accept, div0, sgn_a, sgn_b, last;
    logic [W:0]           mac, shifted, diff;
    logic [2*W-1:0]       mul_nxt, div_nxt, nxt, prod;
    logic [W-1:0]         quo, rem;
    assign accept = state_q == IDLE && start && !cancel;
    assign div0   = op[1] && src_b == '0;
    assign sgn_a  = !op[0] && src_a[W-1];
    assign sgn_b  = !op[0] && src_b[W-1];
    assign last   = cnt_q == CNT_WIDTH'(W - 1);
    // Multiply: acc = {partial product, unconsumed multiplier bits}; add into the top, shift right.
    assign mac     = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_nxt = {mac, acc_q[W-1:1]};
    // Divide: acc = {partial remainder, dividend/quotient}; quotient bits enter at the bottom.
    assign shifted = acc_q[2*W-1:W-1];
    assign diff    = shifted - {1'b0, b_q};
    assign div_nxt = {diff[W] ? shifted[W-1:0] : diff[W-1:0], acc_q[W-2:0], ~diff[W]};
    assign nxt     = div_q ? div_nxt : mul_nxt;
    assign prod    = (sa_q ^ sb_q) ? -nxt : nxt;
    assign quo     = (sa_q ^ sb_q) ? -nxt[W-1:0] : nxt[W-1:0];
    assign rem     = sa_q ? -nxt[2*W-1:W] : nxt[2*W-1:W];
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: if (accept) begin
                sa_d    = sgn_a;
                sb_d    = sgn_b;
                div_d   = op[1];
                b_d     = sgn_b ? -src_b : src_b;
                acc_d   = {{W{1'b0}}, sgn_a ? -src_a : src_a};
                cnt_d   = '0;
                state_d = div0 ? DONE : CALC;
                hi_d    = div0 ? src_a : hi_q;
                lo_d    = div0 ? '1 : lo_q;
            end
            CALC: if (cancel) begin
                state_d = IDLE;
            end else begin
                acc_d   = nxt;
                cnt_d   = cnt_q + CNT_WIDTH'(1);
                state_d = last ? DONE : CALC;
                hi_d    = last ? (div_q ? rem : prod[2*W-1:W]) : hi_q;
                lo_d    = last ? (div_q ? quo : prod[W-1:0]) : lo_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
    assign busy      = state_q != IDLE;
    assign stall_req = accept || state_q == CALC;
    assign done      = state_q == DONE && !cancel;
    assign we_hi     = done;
    assign we_lo     = done;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed self-checking bench for muldiv_seq against an arithmetic reference model
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst, start, cancel;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        stall_req, busy, done, we_hi, we_lo;
    logic [31:0] hi_out, lo_out;
    int          checks = 0;
    int          failures = 0;
    muldiv_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .cancel(cancel), .stall_req(stall_req), .busy(busy), .done(done),
        .we_hi(we_hi), .we_lo(we_lo), .hi_out(hi_out), .lo_out(lo_out)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        x = longint'($signed(a));
        y = longint'($signed(b));
        case (o)
            2'd0: return x * y;
            2'd1: return {32'b0, a} * {32'b0, b};
            2'd2: begin
                if (b == 0) return {a, 32'hffff_ffff};
                q = x / y;
                r = x % y;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hffff_ffff};
                return {a % b, a / b};
            end
        endcase
    endfunction
    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hffff_ffff;
            3: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction
    // Called at a negedge (+ settle); issues one request and follows it to completion or cancel.
    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int cancel_at);
        logic [63:0] e;
        int lat, k, bad;
        e   = model(o, a, b);
        lat = (o[1] && b == 0) ? 1 : 33;
        bad = 0;
        start = 1'b1; op = o; src_a = a; src_b = b; cancel = 1'b0;
        #1 chk("stall_at_start", stall_req, 1);
        chk("busy_at_start", busy, 0);
        @(negedge clk);
        k = 1;
        start = $urandom; op = $urandom; src_a = $urandom; src_b = $urandom;
        while (k <= lat + 3) begin
            if (k == cancel_at) begin
                cancel = 1'b1; start = 1'b0;
                #1 chk("cancel_pulse", {done, we_hi, we_lo}, 0);
                @(negedge clk);
                cancel = 1'b0;
                #1 chk("cancel_idle", {busy, done, we_hi, we_lo}, 0);
                return;
            end
            #1;
            if (done) break;
            if (!stall_req || !busy) bad++;
            @(negedge clk);
            k++;
            start = $urandom; op = $urandom; src_a = $urandom; src_b = $urandom;
        end
        start = 1'b0;
        chk("latency", k, lat);
        chk("stall_busy_calc", bad, 0);
        chk("result", {hi_out, lo_out}, e);
        chk("we_pulse", {done, we_hi, we_lo}, 3'b111);
        chk("stall_in_done", stall_req, 0);
        @(negedge clk);
        #1 chk("hold", {hi_out, lo_out}, e);
        chk("idle_after", {busy, done, we_hi, we_lo, stall_req}, 0);
    endtask
    initial begin
        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        #1 chk("reset_ctrl", {stall_req, busy, done, we_hi, we_lo}, 0);
        chk("reset_data", {hi_out, lo_out}, 0);
        rst = 1'b0;
        @(negedge clk);
        run(2'd0, 32'hffff_fffd, 32'd7, -1);
        chk("mult_spec", {hi_out, lo_out}, 64'hffff_ffff_ffff_ffeb);
        run(2'd1, 32'hffff_ffff, 32'hffff_ffff, -1);
        chk("multu_spec", {hi_out, lo_out}, 64'hffff_fffe_0000_0001);
        run(2'd2, -32'sd7, 32'd2, -1);
        chk("div_neg_spec", {hi_out, lo_out}, 64'hffff_ffff_ffff_fffd);
        run(2'd3, 32'd7, 32'd2, -1);
        chk("divu_spec", {hi_out, lo_out}, 64'h0000_0001_0000_0003);
        run(2'd2, 32'd5, 32'd0, -1);
        chk("div0_spec", {hi_out, lo_out}, 64'h0000_0005_ffff_ffff);
        run(2'd2, 32'h8000_0000, 32'hffff_ffff, -1);
        chk("div_ovf_spec", {hi_out, lo_out}, 64'h0000_0000_8000_0000);
        run(2'd0, 32'h1234_5678, 32'h9abc_def0, 10);
        run(2'd3, 32'd100, 32'd7, -1);
        run(2'd1, $urandom, $urandom, 33);
        run(2'd3, 32'd9, 32'd0, 1);
        run(2'd2, 32'd1000, 32'hffff_fffd, -1);
        start = 1'b1; op = 2'd0; src_a = 32'hdead_beef; src_b = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_mid_ctrl", {stall_req, busy, done, we_hi, we_lo}, 0);
        chk("rst_mid_data", {hi_out, lo_out}, 0);
        for (int i = 0; i < 40; i++) run(2'($urandom), pick(), pick(), ($urandom % 10 == 0) ? int'($urandom_range(1, 33)) : -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
